// File: rtl/prei_org_buf_if.sv
// Write-loader and md_* read bus of the prei original-pixel buffer.
// master = loader/fetcher side, slave = the buffer.
interface prei_org_buf_if;
  logic         wr_en_i;
  logic [5:0]   wr_y_i;
  logic [2:0]   wr_x_i;
  logic [63:0]  wr_data_i;
  logic         md_ren_i;
  logic         md_sel_i;
  logic [1:0]   md_size_i;
  logic [3:0]   md_4x4_x_i;
  logic [3:0]   md_4x4_y_i;
  logic [4:0]   md_idx_i;
  logic [255:0] md_data_o;

  modport master (
    output wr_en_i, wr_y_i, wr_x_i, wr_data_i,
    output md_ren_i, md_sel_i, md_size_i, md_4x4_x_i, md_4x4_y_i, md_idx_i,
    input  md_data_o
  );
  modport slave (
    input  wr_en_i, wr_y_i, wr_x_i, wr_data_i,
    input  md_ren_i, md_sel_i, md_size_i, md_4x4_x_i, md_4x4_y_i, md_idx_i,
    output md_data_o
  );
endinterface

// File: rtl/prei_org_buf.sv
// Ping-pong 2x64x64 luma original-pixel buffer: 8-pixel writes, 256-bit md_* reads, 1-cycle latency.
// Optional PREI_ORG_ERR_EN adds rd_err_o flagging chroma requests and row/column wrap.
module prei_org_buf #(
  parameter int PIX_W = 8,
  parameter int LCU_W = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic sys_start_i,
  output logic load_done_o,
`ifdef PREI_ORG_ERR_EN
  output logic rd_err_o,
`endif
  prei_org_buf_if.slave bus
);
  localparam int AW = $clog2(LCU_W);

  logic [PIX_W-1:0] r_mem [2][LCU_W][LCU_W];
  logic             r_wr_bank;
  logic             r_load_done;
  logic [9:0]       r_load_cnt;
  logic [255:0]     r_md_data;

  logic             w_wr_acc;
  logic             w_swap;
  logic [255:0]     w_rd;
  logic [2:0]       w_lg;
  logic [2:0]       w_rows;
  logic [4:0]       w_k;
  logic [4:0]       w_i;
  logic [AW:0]      w_row;
  logic [AW:0]      w_col;

  assign w_wr_acc = bus.wr_en_i & ~r_load_done;
  assign w_swap   = sys_start_i & r_load_done;

  // Pixel storage carries no reset; stale contents survive a reset mid-load.
  always_ff @(posedge clk) begin
    if (w_wr_acc)
      for (int j = 0; j < 8; j++)
        r_mem[r_wr_bank][bus.wr_y_i][{bus.wr_x_i, 3'(j)}] <= bus.wr_data_i[63-PIX_W*j -: PIX_W];
  end

  // Beat = w_rows rows of (1<<w_lg) pixels, packed row-major MSB-first from the read bank.
`ifdef PREI_ORG_ERR_EN
  logic w_wrap;
`endif
  always_comb begin
    w_rd  = '0;
    w_k   = '0;
    w_i   = '0;
    w_row = '0;
    w_col = '0;
`ifdef PREI_ORG_ERR_EN
    w_wrap = 1'b0;
`endif
    case (bus.md_size_i)
      2'b00:   begin w_lg = 3'd2; w_rows = 3'd4; end
      2'b01:   begin w_lg = 3'd3; w_rows = 3'd4; end
      2'b10:   begin w_lg = 3'd4; w_rows = 3'd2; end
      default: begin w_lg = 3'd5; w_rows = 3'd1; end
    endcase
    for (int p = 0; p < 32; p++) begin
      w_k = 5'(p >> w_lg);
      w_i = 5'(p) & ((5'd1 << w_lg) - 5'd1);
      if (w_k < 5'(w_rows)) begin
        w_row = {1'b0, bus.md_4x4_y_i, 2'b00} + (AW+1)'(bus.md_idx_i) + (AW+1)'(w_k);
        w_col = {1'b0, bus.md_4x4_x_i, 2'b00} + (AW+1)'(w_i);
        w_rd[255-PIX_W*p -: PIX_W] = r_mem[~r_wr_bank][w_row[AW-1:0]][w_col[AW-1:0]];
`ifdef PREI_ORG_ERR_EN
        w_wrap = w_wrap | w_row[AW] | w_col[AW];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_md_data   <= '0;
      r_wr_bank   <= 1'b0;
      r_load_cnt  <= '0;
      r_load_done <= 1'b0;
    end else begin
      if (bus.md_ren_i)
        r_md_data <= bus.md_sel_i ? '0 : w_rd;
      // Swap needs a full bank, and writes stop once full, so the two never coincide.
      if (w_swap) begin
        r_wr_bank   <= ~r_wr_bank;
        r_load_cnt  <= '0;
        r_load_done <= 1'b0;
      end else if (w_wr_acc) begin
        r_load_cnt <= r_load_cnt + 10'd1;
        if (r_load_cnt == 10'd511)
          r_load_done <= 1'b1;
      end
    end
  end

`ifdef PREI_ORG_ERR_EN
  logic r_rd_err;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rd_err <= 1'b0;
    else       r_rd_err <= bus.md_ren_i & (bus.md_sel_i | w_wrap);
  end
  assign rd_err_o = r_rd_err;
`endif

  assign bus.md_data_o = r_md_data;
  assign load_done_o   = r_load_done;
endmodule

// File: tb/tb_prei_org_buf.sv
// Bench for prei_org_buf: per-cycle reference model of banks/load/swap/reads,
// a table of known-answer reads, and directed swap/reset sequences.
module tb_prei_org_buf;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sys_start = 1'b0;
  logic load_done;
`ifdef PREI_ORG_ERR_EN
  logic rd_err;
`endif

  prei_org_buf_if bus();

  prei_org_buf dut (
    .clk         (clk),
    .rstn        (rstn),
    .sys_start_i (sys_start),
    .load_done_o (load_done),
`ifdef PREI_ORG_ERR_EN
    .rd_err_o    (rd_err),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]   mdl [2][64][64];
  logic         m_bank;
  logic         m_done;
  int           m_cnt;
  logic [255:0] m_data;
  logic         m_err;

  typedef struct {
    int         size, x, y, idx, sel;
    logic [7:0] msb, lsb;
    logic       err;
  } vec_t;
  vec_t tv[7];

  function automatic logic [7:0] pix(int pat, int x, int y);
    case (pat)
      0:       return 8'((x + y) & 255);
      1:       return 8'((3*x + 5*y + 64) & 255);
      default: return 8'((7*x + y*y + 17) & 255);
    endcase
  endfunction

  function automatic logic [255:0] ref_rd(logic bank, int size, int x, int y, int idx,
                                          output logic wrap);
    int rows, w, r, c;
    logic [255:0] d;
    w    = 4 << size;
    rows = (size < 2) ? 4 : (size == 2) ? 2 : 1;
    d    = '0;
    wrap = 1'b0;
    for (int k = 0; k < rows; k++)
      for (int i = 0; i < w; i++) begin
        r = y*4 + idx + k;
        c = x*4 + i;
        if (r > 63 || c > 63) wrap = 1'b1;
        d[255 - 8*(k*w + i) -: 8] = mdl[bank][r % 64][c % 64];
      end
    return d;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock: update the model from the current inputs, then compare outputs
  task automatic cyc();
    logic w;
    logic [255:0] d;
    if (!rstn) begin
      m_bank = 1'b0; m_cnt = 0; m_done = 1'b0; m_data = '0; m_err = 1'b0;
    end else begin
      if (bus.md_ren_i) begin
        d = ref_rd(!m_bank, int'(bus.md_size_i), int'(bus.md_4x4_x_i),
                   int'(bus.md_4x4_y_i), int'(bus.md_idx_i), w);
        m_data = bus.md_sel_i ? '0 : d;
        m_err  = bus.md_sel_i | w;
      end else m_err = 1'b0;
      if (sys_start && m_done) begin
        m_bank = !m_bank; m_cnt = 0; m_done = 1'b0;
      end else if (bus.wr_en_i && !m_done) begin
        for (int j = 0; j < 8; j++)
          mdl[m_bank][bus.wr_y_i][bus.wr_x_i*8 + j] = bus.wr_data_i[63-8*j -: 8];
        m_cnt++;
        if (m_cnt == 512) m_done = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("md_data", bus.md_data_o, m_data);
    chk("load_done", 256'(load_done), 256'(m_done));
`ifdef PREI_ORG_ERR_EN
    chk("rd_err", 256'(rd_err), 256'(m_err));
`endif
  endtask

  task automatic wr_px(int pat, int x, int y);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[63-8*j -: 8] = pix(pat, x*8 + j, y);
    bus.wr_en_i = 1'b1; bus.wr_x_i = 3'(x); bus.wr_y_i = 6'(y); bus.wr_data_i = d;
    cyc();
    bus.wr_en_i = 1'b0;
  endtask

  // writes n addresses of a fixed permutation of the 512 slots, starting at slot s
  task automatic load_perm(int pat, int s, int n);
    int a;
    for (int k = s; k < s + n; k++) begin
      a = (k*37 + 5) % 512;
      wr_px(pat, a & 7, a >> 3);
    end
  endtask

  task automatic set_rd(int size, int x, int y, int idx, int sel);
    bus.md_ren_i = 1'b1; bus.md_size_i = 2'(size); bus.md_4x4_x_i = 4'(x);
    bus.md_4x4_y_i = 4'(y); bus.md_idx_i = 5'(idx); bus.md_sel_i = sel[0];
  endtask

  task automatic rd(int size, int x, int y, int idx, int sel);
    set_rd(size, x, y, idx, sel);
    cyc();
    bus.md_ren_i = 1'b0;
  endtask

  task automatic rand_rd(int n);
    for (int k = 0; k < n; k++) begin
      rd($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
         $urandom_range(0, 31), ($urandom_range(0, 7) == 0) ? 1 : 0);
      if ($urandom_range(0, 3) == 0) cyc();
    end
  endtask

  initial begin
    tv[0] = '{size:1, x:2,  y:2,  idx:0, sel:0, msb:8'h10, lsb:8'h1A, err:1'b0};
    tv[1] = '{size:1, x:2,  y:2,  idx:4, sel:0, msb:8'h14, lsb:8'h1E, err:1'b0};
    tv[2] = '{size:2, x:0,  y:15, idx:1, sel:0, msb:8'h3D, lsb:8'h4D, err:1'b0};
    tv[3] = '{size:3, x:0,  y:15, idx:4, sel:0, msb:8'h00, lsb:8'h1F, err:1'b1};
    tv[4] = '{size:0, x:15, y:0,  idx:0, sel:0, msb:8'h3C, lsb:8'h00, err:1'b0};
    tv[5] = '{size:3, x:10, y:0,  idx:0, sel:0, msb:8'h28, lsb:8'h07, err:1'b1};
    tv[6] = '{size:1, x:3,  y:3,  idx:2, sel:1, msb:8'h00, lsb:8'h00, err:1'b1};

    for (int b = 0; b < 2; b++)
      for (int y = 0; y < 64; y++)
        for (int x = 0; x < 64; x++) mdl[b][y][x] = 8'h00;
    m_bank = 1'b0; m_cnt = 0; m_done = 1'b0; m_data = '0; m_err = 1'b0;
    bus.wr_en_i = 1'b0; bus.wr_x_i = '0; bus.wr_y_i = '0; bus.wr_data_i = '0;
    bus.md_ren_i = 1'b0; bus.md_sel_i = 1'b0; bus.md_size_i = '0;
    bus.md_4x4_x_i = '0; bus.md_4x4_y_i = '0; bus.md_idx_i = '0;

    // reset state
    @(posedge clk); #1;
    chk("rst_md_data", bus.md_data_o, '0);
    chk("rst_load_done", 256'(load_done), 256'(0));
    rstn = 1'b1;
    cyc();

    // bank 0 full load in row order; done follows the 512th write
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 8; x++) wr_px(0, x, y);
    chk("done_after_512", 256'(load_done), 256'(1));
    bus.wr_data_i = '1;
    bus.wr_en_i = 1'b1; bus.wr_x_i = '0; bus.wr_y_i = '0;
    cyc();
    bus.wr_en_i = 1'b0;
    sys_start = 1'b1; cyc(); sys_start = 1'b0;
    chk("done_clr_on_swap", 256'(load_done), 256'(0));

    // known-answer reads from bank 0
    for (int t = 0; t < 7; t++) begin
      rd(tv[t].size, tv[t].x, tv[t].y, tv[t].idx, tv[t].sel);
      chk($sformatf("tv%0d_msb", t), 256'(bus.md_data_o[255:248]), 256'(tv[t].msb));
      chk($sformatf("tv%0d_lsb", t), 256'(bus.md_data_o[7:0]), 256'(tv[t].lsb));
`ifdef PREI_ORG_ERR_EN
      chk($sformatf("tv%0d_err", t), 256'(rd_err), 256'(tv[t].err));
`endif
    end
    rand_rd(150);

    // 100 writes into bank 1, then a swap pulse that must be ignored
    load_perm(1, 0, 100);
    sys_start = 1'b1;
    rd(1, 2, 2, 0, 0);
    sys_start = 1'b0;
    chk("early_swap_done", 256'(load_done), 256'(0));
    chk("early_swap_old_bank", 256'(bus.md_data_o[255:248]), 256'(8'h10));
    rand_rd(20);
    load_perm(1, 100, 412);
    chk("bank1_done", 256'(load_done), 256'(1));

    // read in the swap cycle sees the old bank, next read sees the new one
    sys_start = 1'b1;
    set_rd(3, 0, 0, 0, 0);
    cyc();
    sys_start = 1'b0;
    chk("swap_cycle_rd", 256'(bus.md_data_o[255:248]), 256'(pix(0, 0, 0)));
    cyc();
    chk("post_swap_rd", 256'(bus.md_data_o[255:248]), 256'(pix(1, 0, 0)));
    bus.md_ren_i = 1'b0;
    rand_rd(150);

    // reset in the middle of loading bank 0
    load_perm(2, 0, 50);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_md_data", bus.md_data_o, '0);
    chk("async_rst_done", 256'(load_done), 256'(0));
    cyc();
    cyc();
    rstn = 1'b1;
    load_perm(2, 7, 511);
    chk("reload_not_done_511", 256'(load_done), 256'(0));
    load_perm(2, 0, 1);
    chk("reload_done", 256'(load_done), 256'(1));
    sys_start = 1'b1; cyc(); sys_start = 1'b0;
    rand_rd(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
